div_bus_master: RTL and testbench

DIV_BUS_MASTER -- requirements
Module: div_bus_master

---
 rtl/div_bus_master.sv | 192 +++++++++++++++++++
 tb/tb_div_bus_master.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_bus_master.sv
`default_nettype none
// div_bus_master: byte-serial master for a handshake divider; sends 4 operand bytes, collects 4 result bytes.
// Revision 1.0
module div_bus_master #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [15:0] req_dividend,
  input  logic [15:0] req_divisor,
  output logic        req_ready,
  input  logic        div_ready,
  output logic        div_start,
  output logic [7:0]  div_bus_out,
  input  logic        div_full,
  input  logic [7:0]  div_bus_in,
  output logic        div_received,
  output logic        rsp_valid,
  input  logic        rsp_ack,
  output logic [15:0] rsp_quotient,
  output logic [15:0] rsp_remainder,
  output logic        rsp_err
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_TX_WAIT  = 4'd1;
  localparam logic [3:0] S_TX_SETUP = 4'd2;
  localparam logic [3:0] S_TX_PULSE = 4'd3;
  localparam logic [3:0] S_TX_HOLD  = 4'd4;
  localparam logic [3:0] S_RX_WAIT  = 4'd5;
  localparam logic [3:0] S_RX_PULSE = 4'd6;
  localparam logic [3:0] S_RX_GAP   = 4'd7;
  localparam logic [3:0] S_RESP     = 4'd8;

  localparam logic [3:0]  C_PULSE_LAST = 4'(PULSE_W - 1);
  localparam logic [3:0]  C_GAP_LAST   = 4'(GAP_W - 1);
  localparam logic [15:0] C_TIMEOUT    = 16'(TIMEOUT);

  logic [3:0]  state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [3:0]  phase_cnt_q, phase_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] dividend_q, dividend_d;
  logic [15:0] divisor_q, divisor_d;
  logic [15:0] quot_q, quot_d;
  logic [15:0] rem_q, rem_d;
  logic        err_q, err_d;
  logic [15:0] wait_inc;
  logic [7:0]  tx_byte;

  assign wait_inc = wait_cnt_q + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= 2'd0;
      phase_cnt_q <= 4'd0;
      wait_cnt_q  <= 16'd0;
      dividend_q  <= 16'd0;
      divisor_q   <= 16'd0;
      quot_q      <= 16'd0;
      rem_q       <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    phase_cnt_d = phase_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          dividend_d = req_dividend;
          divisor_d  = req_divisor;
          quot_d     = 16'd0;
          rem_d      = 16'd0;
          err_d      = 1'b0;
          byte_cnt_d = 2'd0;
          wait_cnt_d = 16'd0;
          state_d    = S_TX_WAIT;
        end
      end
      S_TX_WAIT, S_RX_WAIT: begin
        if (state_q == S_TX_WAIT && div_ready) begin
          state_d = S_TX_SETUP;
        end else if (state_q == S_RX_WAIT && div_full) begin
          case (byte_cnt_q)
            2'd0: quot_d[15:8] = div_bus_in;
            2'd1: quot_d[7:0]  = div_bus_in;
            2'd2: rem_d[15:8]  = div_bus_in;
            2'd3: rem_d[7:0]   = div_bus_in;
          endcase
          phase_cnt_d = 4'd0;
          state_d     = S_RX_PULSE;
        end else if (wait_inc == C_TIMEOUT) begin
          // Abort: partially collected result bytes are discarded.
          quot_d     = 16'd0;
          rem_d      = 16'd0;
          err_d      = 1'b1;
          byte_cnt_d = 2'd0;
          state_d    = S_RESP;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      S_TX_SETUP: begin
        phase_cnt_d = 4'd0;
        state_d     = S_TX_PULSE;
      end
      S_TX_PULSE, S_RX_PULSE: begin
        if (phase_cnt_q == C_PULSE_LAST) begin
          phase_cnt_d = 4'd0;
          state_d     = (state_q == S_TX_PULSE) ? S_TX_HOLD : S_RX_GAP;
        end else begin
          phase_cnt_d = phase_cnt_q + 4'd1;
        end
      end
      S_TX_HOLD, S_RX_GAP: begin
        if (phase_cnt_q == C_GAP_LAST) begin
          phase_cnt_d = 4'd0;
          byte_cnt_d  = byte_cnt_q + 2'd1;
          wait_cnt_d  = 16'd0;
          if (state_q == S_TX_HOLD) begin
            state_d = (byte_cnt_q == 2'd3) ? S_RX_WAIT : S_TX_WAIT;
          end else begin
            state_d = (byte_cnt_q == 2'd3) ? S_RESP : S_RX_WAIT;
          end
        end else begin
          phase_cnt_d = phase_cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (byte_cnt_q)
      2'd0: tx_byte = dividend_q[15:8];
      2'd1: tx_byte = dividend_q[7:0];
      2'd2: tx_byte = divisor_q[15:8];
      2'd3: tx_byte = divisor_q[7:0];
    endcase
  end

  always_comb begin
    req_ready    = 1'b0;
    div_start    = 1'b0;
    div_received = 1'b0;
    rsp_valid    = 1'b0;
    div_bus_out  = 8'h00;
    case (state_q)
      S_IDLE:                req_ready = 1'b1;
      S_TX_SETUP, S_TX_HOLD: div_bus_out = tx_byte;
      S_TX_PULSE: begin
        div_bus_out = tx_byte;
        div_start   = 1'b1;
      end
      S_RX_PULSE:            div_received = 1'b1;
      S_RESP:                rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_quotient  = quot_q;
  assign rsp_remainder = rem_q;
  assign rsp_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_div_bus_master.sv
`default_nettype none
// tb_div_bus_master: vector table, directed corner cases and randomized transactions against a divider model.
// Revision 1.0
module tb_div_bus_master;

  localparam int P_PULSE = 3;
  localparam int P_GAP   = 2;
  localparam int P_TO    = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [15:0] req_dividend = 16'd0;
  logic [15:0] req_divisor = 16'd0;
  logic        div_ready = 1'b1;
  logic        div_full = 1'b0;
  logic [7:0]  div_bus_in = 8'h00;
  logic        rsp_ack = 1'b0;
  logic        req_ready, div_start, div_received, rsp_valid, rsp_err;
  logic [7:0]  div_bus_out;
  logic [15:0] rsp_quotient, rsp_remainder;

  int n_tests = 0;
  int n_fail = 0;
  int ready_mode = 0;
  int model_limit = 4;
  logic [7:0] sent_q[$];

  div_bus_master #(.PULSE_W(P_PULSE), .GAP_W(P_GAP), .TIMEOUT(P_TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor), .req_ready(req_ready),
    .div_ready(div_ready), .div_start(div_start), .div_bus_out(div_bus_out),
    .div_full(div_full), .div_bus_in(div_bus_in), .div_received(div_received),
    .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_quotient(rsp_quotient),
    .rsp_remainder(rsp_remainder), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Divider model: takes 4 operand bytes on div_start rises, returns up to model_limit result bytes.
  initial begin : divider_model
    logic [7:0]  m_bytes[4];
    logic [7:0]  m_out[$];
    logic [15:0] a, b, q, r;
    logic [31:0] res;
    logic        m_prev;
    int          m_cnt, m_delay;
    m_cnt = 0; m_prev = 1'b0; m_delay = 0;
    forever begin
      @(negedge clk);
      if (ready_mode != 0) div_ready = ($urandom_range(0, 3) != 0);
      if (!rst) begin
        m_cnt = 0; m_prev = 1'b0; m_out.delete();
        div_full = 1'b0; div_bus_in = 8'h00;
      end else begin
        if (div_start && !m_prev) begin
          m_bytes[m_cnt] = div_bus_out;
          m_cnt++;
          if (m_cnt == 4) begin
            m_cnt = 0;
            a = {m_bytes[0], m_bytes[1]};
            b = {m_bytes[2], m_bytes[3]};
            q = (b == 16'd0) ? 16'hFFFF : a / b;
            r = (b == 16'd0) ? a : a % b;
            res = {q, r};
            for (int i = 0; i < model_limit; i++) m_out.push_back(res[31-8*i -: 8]);
          end
        end
        m_prev = div_start;
        if (div_full) begin
          if (div_received) begin
            div_full = 1'b0; div_bus_in = 8'h00;
            void'(m_out.pop_front());
            m_delay = $urandom_range(0, 3);
          end
        end else if (m_out.size() != 0 && !div_received) begin
          if (m_delay == 0) begin
            div_full = 1'b1; div_bus_in = m_out[0];
          end else begin
            m_delay--;
          end
        end
      end
    end
  end

  initial begin : protocol_monitor
    logic p_prev_s, p_prev_r;
    logic [7:0] p_prev_bus, p_val;
    int p_slen, p_rlen, p_hold;
    p_prev_s = 1'b0; p_prev_r = 1'b0; p_prev_bus = 8'h00; p_val = 8'h00;
    p_slen = 0; p_rlen = 0; p_hold = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        p_prev_s = 1'b0; p_prev_r = 1'b0; p_hold = 0; p_slen = 0; p_rlen = 0;
        p_prev_bus = div_bus_out;
      end else begin
        check("start_recv_exclusive", 32'(div_start & div_received), 32'd0);
        if (div_start && !p_prev_s) begin
          check("setup_bus_stable", 32'(div_bus_out), 32'(p_prev_bus));
          p_val = div_bus_out; p_slen = 1;
          sent_q.push_back(div_bus_out);
        end else if (div_start) begin
          check("pulse_bus_stable", 32'(div_bus_out), 32'(p_val));
          p_slen++;
        end else if (p_prev_s) begin
          check("start_width", p_slen, P_PULSE);
          p_hold = P_GAP;
        end
        if (!div_start && p_hold > 0) begin
          check("hold_bus_stable", 32'(div_bus_out), 32'(p_val));
          p_hold--;
        end
        if (div_received) begin
          p_rlen++;
        end else if (p_prev_r) begin
          check("recv_width", p_rlen, P_PULSE);
          p_rlen = 0;
        end
        p_prev_s = div_start; p_prev_r = div_received; p_prev_bus = div_bus_out;
      end
    end
  end

  task automatic do_txn(input logic [15:0] a, input logic [15:0] b, input int ack_delay,
                        output logic [15:0] q, output logic [15:0] r, output logic e);
    int k;
    logic [15:0] hq, hr;
    logic he;
    logic [31:0] ops;
    q = 16'd0; r = 16'd0; e = 1'b0;
    k = 0;
    while (!req_ready && k < 200) begin @(negedge clk); k++; end
    check("req_ready_before_txn", 32'(req_ready), 32'd1);
    sent_q.delete();
    req_dividend = a; req_divisor = b; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_dividend = 16'($urandom); req_divisor = 16'($urandom);
    check("req_ready_after_accept", 32'(req_ready), 32'd0);
    rsp_ack = 1'b1;
    @(negedge clk);
    rsp_ack = 1'b0;
    k = 0;
    while (!rsp_valid && k < 3000) begin @(negedge clk); k++; end
    check("rsp_valid_in_time", 32'(rsp_valid), 32'd1);
    hq = rsp_quotient; hr = rsp_remainder; he = rsp_err;
    ops = {a, b};
    check("sent_count", sent_q.size(), 4);
    for (int i = 0; i < 4 && i < sent_q.size(); i++)
      check("sent_byte", 32'(sent_q[i]), 32'(ops[31-8*i -: 8]));
    for (int i = 0; i < ack_delay; i++) begin
      req_valid = 1'b1; req_dividend = 16'($urandom); req_divisor = 16'($urandom);
      @(negedge clk);
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_quotient", 32'(rsp_quotient), 32'(hq));
      check("hold_remainder", 32'(rsp_remainder), 32'(hr));
      check("hold_err", 32'(rsp_err), 32'(he));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0; rsp_ack = 1'b1;
    @(negedge clk);
    rsp_ack = 1'b0;
    check("rsp_valid_after_ack", 32'(rsp_valid), 32'd0);
    check("req_ready_after_ack", 32'(req_ready), 32'd1);
    q = hq; r = hr; e = he;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
  } vec_t;

  initial begin : main
    vec_t vecs[8];
    logic [15:0] q, r, a, b, eq, er;
    logic e, seen;
    int k, n, rises;
    logic prev;

    vecs[0] = '{16'd25,    16'd5,     16'd5,     16'd0};
    vecs[1] = '{16'd100,   16'd7,     16'd14,    16'd2};
    vecs[2] = '{16'd65535, 16'd1,     16'd65535, 16'd0};
    vecs[3] = '{16'd0,     16'd3,     16'd0,     16'd0};
    vecs[4] = '{16'd1000,  16'd33,    16'd30,    16'd10};
    vecs[5] = '{16'hFFFF,  16'h0100,  16'h00FF,  16'h00FF};
    vecs[6] = '{16'd7,     16'd0,     16'hFFFF,  16'd7};
    vecs[7] = '{16'd5,     16'd9,     16'd0,     16'd5};

    repeat (3) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_div_start", 32'(div_start), 32'd0);
    check("reset_div_received", 32'(div_received), 32'd0);
    check("reset_bus_out", 32'(div_bus_out), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_quotient", 32'(rsp_quotient), 32'd0);
    check("reset_remainder", 32'(rsp_remainder), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].a, vecs[i].b, i % 3, q, r, e);
      check("vec_quotient", 32'(q), 32'(vecs[i].q));
      check("vec_remainder", 32'(r), 32'(vecs[i].r));
      check("vec_err", 32'(e), 32'd0);
    end

    // Response held 20 cycles while a competing request is presented.
    do_txn(16'd25, 16'd5, 20, q, r, e);
    check("hold_final_quotient", 32'(q), 32'd5);
    check("hold_final_remainder", 32'(r), 32'd0);

    // Back-pressure ahead of byte 3.
    fork
      begin
        do_txn(16'd1234, 16'd56, 0, q, r, e);
      end
      begin : bp_drv
        int falls, kk;
        logic pv;
        falls = 0; kk = 0; pv = 1'b0;
        while (falls < 2 && kk < 500) begin
          @(negedge clk);
          if (pv && !div_start) falls++;
          pv = div_start; kk++;
        end
        check("bp_reached_byte3", falls, 2);
        div_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
          @(negedge clk);
          check("bp_no_start", 32'(div_start), 32'd0);
          if (i >= P_GAP) check("bp_bus_idle", 32'(div_bus_out), 32'd0);
        end
        check("bp_bytes_sent", sent_q.size(), 2);
        div_ready = 1'b1;
      end
    join
    check("bp_quotient", 32'(q), 32'd22);
    check("bp_remainder", 32'(r), 32'd2);
    check("bp_err", 32'(e), 32'd0);

    // Timeout with no result bytes: exact wait length.
    model_limit = 0;
    fork
      begin
        do_txn(16'd77, 16'd7, 2, q, r, e);
      end
      begin : to_watch
        int falls, kk, cnt;
        logic pv;
        falls = 0; kk = 0; pv = 1'b0; cnt = 1;
        while (falls < 4 && kk < 1000) begin
          @(negedge clk);
          if (pv && !div_start) falls++;
          pv = div_start; kk++;
        end
        check("to_all_bytes_sent", falls, 4);
        while (!rsp_valid && cnt < 2000) begin @(negedge clk); cnt++; end
        check("to_latency", cnt, P_GAP + P_TO + 1);
      end
    join
    check("to_err", 32'(e), 32'd1);
    check("to_quotient", 32'(q), 32'd0);
    check("to_remainder", 32'(r), 32'd0);

    // Timeout after two result bytes: partial quotient must be discarded.
    model_limit = 2;
    do_txn(16'd1000, 16'd10, 0, q, r, e);
    check("partial_err", 32'(e), 32'd1);
    check("partial_quotient", 32'(q), 32'd0);
    check("partial_remainder", 32'(r), 32'd0);
    model_limit = 4;

    // Reset during byte 2 pulse.
    sent_q.delete();
    req_dividend = 16'd500; req_divisor = 16'd3; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rises = 0; k = 0; prev = 1'b0;
    while (rises < 2 && k < 500) begin
      @(negedge clk);
      if (div_start && !prev) rises++;
      prev = div_start; k++;
    end
    check("rst_reached_byte2", rises, 2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_div_start", 32'(div_start), 32'd0);
    check("rst_bus_out", 32'(div_bus_out), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_quotient", 32'(rsp_quotient), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid || div_start) seen = 1'b1;
    end
    check("rst_no_resume", 32'(seen), 32'd0);
    do_txn(16'd100, 16'd7, 0, q, r, e);
    check("rst_after_quotient", 32'(q), 32'd14);
    check("rst_after_remainder", 32'(r), 32'd2);
    check("rst_after_err", 32'(e), 32'd0);

    // Randomized transactions under random div_ready back-pressure.
    ready_mode = 1;
    for (int i = 0; i < 25; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'd0;
        1, 2, 3: b = 16'($urandom_range(1, 255));
        default: b = 16'($urandom);
      endcase
      eq = (b == 16'd0) ? 16'hFFFF : a / b;
      er = (b == 16'd0) ? a : a % b;
      do_txn(a, b, $urandom_range(0, 3), q, r, e);
      check("rand_quotient", 32'(q), 32'(eq));
      check("rand_remainder", 32'(r), 32'(er));
      check("rand_err", 32'(e), 32'd0);
    end
    ready_mode = 0;
    div_ready = 1'b1;

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
